// File: rtl/i2c_master_burst.sv
// i2c_master_burst: register-addressed I2C master moving 1..NBYTES bytes per transaction.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_burst #(
    parameter int NBYTES  = 2,
    parameter int CNT_W   = $clog2(NBYTES + 1),
    parameter int CLK_DIV = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                rw,
    input  logic [6:0]          addr,
    input  logic [7:0]          reg_addr,
    input  logic [8*NBYTES-1:0] data,
    input  logic [CNT_W-1:0]    nbytes,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [8*NBYTES-1:0] data_o,
    input  logic                sda_i,
    output logic                sda_oe,
    input  logic                scl_i,
    output logic                scl_oe,
    output logic [4:0]          state_o
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'd0,
        START  = 5'd1,
        ADDR_W = 5'd2,
        ACK1   = 5'd9,
        REG    = 5'd10,
        ACK2   = 5'd11,
        WDATA  = 5'd12,
        WACK   = 5'd13,
        RSTART = 5'd14,
        ADDR_R = 5'd15,
        ACK3   = 5'd19,
        RDATA  = 5'd20,
        MACK   = 5'd21,
        STOP   = 5'd30
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [QW-1:0]       qcnt;
    logic [1:0]          q;
    logic [2:0]          bcnt;
    logic [CNT_W-1:0]    bidx;
    logic [CNT_W-1:0]    n_q;
    logic [7:0]          shreg;
    logic [6:0]          addr_q;
    logic [7:0]          reg_q;
    logic [8*NBYTES-1:0] data_q;
    logic                rw_q;
    logic                smp;
    logic                hold;
    logic                tick;
    logic                bit_end;
    logic                stop_end;
    logic                byte_end;
    logic                last;
    logic                scl_low;
    logic                byte_state;

`ifdef I2C_CLK_STRETCH_EN
    // Freeze the quarter counter while a slave holds SCL low after release.
    assign hold = (q == 2'd1) && !scl_oe && !scl_i;
`else
    logic scl_unused;
    assign scl_unused = scl_i;
    assign hold = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign state_o  = state;
    assign tick     = busy && (qcnt == QLAST) && !hold;
    assign bit_end  = tick && (q == 2'd3);
    assign stop_end = tick && (q == 2'd2) && (state == STOP);
    assign byte_end = (bcnt == 3'd7);
    assign last     = (bidx == n_q - CNT_W'(1));
    assign scl_low  = (q == 2'd0) || (q == 2'd3);

    assign byte_state = (state == ADDR_W) || (state == REG) ||
                        (state == WDATA) || (state == ADDR_R) ||
                        (state == RDATA);

    function automatic logic [7:0] pick(
        input logic [8*NBYTES-1:0] d,
        input logic [CNT_W-1:0]    k
    );
        pick = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == CNT_W'(i)) pick = d[8*(NBYTES-i)-1 -: 8];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en) state_n = START;
            START:   if (bit_end) state_n = ADDR_W;
            ADDR_W:  if (bit_end && byte_end) state_n = ACK1;
            ACK1:    if (bit_end) state_n = smp ? STOP : REG;
            REG:     if (bit_end && byte_end) state_n = ACK2;
            ACK2: begin
                if (bit_end) begin
                    if (smp)       state_n = STOP;
                    else if (rw_q) state_n = RSTART;
                    else           state_n = WDATA;
                end
            end
            WDATA:   if (bit_end && byte_end) state_n = WACK;
            WACK:    if (bit_end) state_n = (smp || last) ? STOP : WDATA;
            RSTART:  if (bit_end) state_n = ADDR_R;
            ADDR_R:  if (bit_end && byte_end) state_n = ACK3;
            ACK3:    if (bit_end) state_n = smp ? STOP : RDATA;
            RDATA:   if (bit_end && byte_end) state_n = MACK;
            MACK:    if (bit_end) state_n = last ? STOP : RDATA;
            STOP:    if (stop_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state)
            START: begin
                scl_oe = (q == 2'd3);
                sda_oe = (q != 2'd0);
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl_oe = scl_low;
                sda_oe = !shreg[7];
            end
            ACK1, ACK2, ACK3, WACK, RDATA: scl_oe = scl_low;
            MACK: begin
                scl_oe = scl_low;
                sda_oe = !last;
            end
            RSTART: begin
                scl_oe = scl_low;
                sda_oe = q[1];
            end
            STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = !q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt   <= '0;
            q      <= 2'd0;
            bcnt   <= 3'd0;
            bidx   <= '0;
            n_q    <= '0;
            shreg  <= 8'h00;
            addr_q <= 7'h00;
            reg_q  <= 8'h00;
            data_q <= '0;
            rw_q   <= 1'b0;
            smp    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            data_o <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                qcnt <= '0;
                q    <= 2'd0;
                bcnt <= 3'd0;
                if (en) begin
                    addr_q <= addr;
                    reg_q  <= reg_addr;
                    data_q <= data;
                    rw_q   <= rw;
                    err    <= 1'b0;
                    data_o <= '0;
                    bidx   <= '0;
                    if (nbytes == '0)
                        n_q <= CNT_W'(1);
                    else if (nbytes > CNT_W'(NBYTES))
                        n_q <= CNT_W'(NBYTES);
                    else
                        n_q <= nbytes;
                end
            end else begin
                if (tick) begin
                    qcnt <= '0;
                    q    <= stop_end ? 2'd0 : q + 2'd1;
                end else if (!hold) begin
                    qcnt <= qcnt + QW'(1);
                end
                if (tick && q == 2'd2) begin
                    smp <= sda_i;
                    if (state == RDATA) shreg <= {shreg[6:0], sda_i};
                end
                if (stop_end) done <= 1'b1;
                if (bit_end) begin
                    bcnt <= byte_state ? bcnt + 3'd1 : 3'd0;
                    // Slave ACK slots sampled high abort to STOP.
                    if ((state == ACK1 || state == ACK2 ||
                         state == ACK3 || state == WACK) && smp)
                        err <= 1'b1;
                    unique case (state)
                        START:  shreg <= {addr_q, 1'b0};
                        ADDR_W, REG, WDATA, ADDR_R:
                                shreg <= {shreg[6:0], 1'b0};
                        ACK1:   shreg <= reg_q;
                        ACK2: begin
                            shreg <= pick(data_q, '0);
                            bidx  <= '0;
                        end
                        WACK: begin
                            shreg <= pick(data_q, bidx + CNT_W'(1));
                            bidx  <= bidx + CNT_W'(1);
                        end
                        RSTART: shreg <= {addr_q, 1'b1};
                        ACK3:   bidx <= '0;
                        MACK: begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (bidx == CNT_W'(i))
                                    data_o[8*(NBYTES-i)-1 -: 8] <= shreg;
                            end
                            bidx <= bidx + CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
